// File: rtl/spi_flash_responder.sv
// SPI-flash target emulator: READ (byte stream from a memory port) and JEDEC-ID.
// Ports: clk_i/rst_ni, SPI pins sck_i/cs_n_i/mosi_i/miso_o/miso_oe_o, mem_* read port, busy_o.
module spi_flash_responder #(
    parameter logic [7:0]  READ_CMD    = 8'h03,
    parameter logic [7:0]  JEDEC_CMD   = 8'h9F,
    parameter logic [23:0] JEDEC_ID    = 24'hEF4018,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        sck_i,
    input  logic        cs_n_i,
    input  logic        mosi_i,
    output logic        miso_o,
    output logic        miso_oe_o,
    output logic        mem_req_o,
    output logic [23:0] mem_addr_o,
    input  logic [7:0]  mem_data_i,
    output logic        busy_o
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CMD    = 3'd1;
    localparam logic [2:0] ST_ADDR   = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_ID     = 3'd4;
    localparam logic [2:0] ST_IGNORE = 3'd5;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_q;

    logic sck_s;
    logic cs_s;
    logic mosi_s;
    logic rise;
    logic fall;
    logic desel;

    logic [2:0]  state;
    logic [4:0]  bit_cnt;
    logic [6:0]  cmd_sr;
    logic [22:0] addr_sr;
    logic [7:0]  tx_sr;
    logic [7:0]  hold_q;
    logic [23:0] id_sr;
    logic        pref_pend;
    logic        req_tx;
    logic        rsp_vld;
    logic        rsp_tx;

    logic [7:0]  cmd_nxt;
    logic [23:0] addr_nxt;

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign rise  = sck_s & ~sck_q;
    assign fall  = ~sck_s & sck_q;
    assign desel = cs_s;

    assign cmd_nxt  = {cmd_sr, mosi_s};
    assign addr_nxt = {addr_sr, mosi_s};

    // Chip select resets high so a reset release never looks like a select.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_q     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck_i};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
            sck_q     <= sck_s;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            cmd_sr     <= '0;
            addr_sr    <= '0;
            tx_sr      <= '0;
            hold_q     <= '0;
            id_sr      <= '0;
            pref_pend  <= 1'b0;
            req_tx     <= 1'b0;
            rsp_vld    <= 1'b0;
            rsp_tx     <= 1'b0;
            miso_o     <= 1'b0;
            miso_oe_o  <= 1'b0;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
            busy_o     <= 1'b0;
        end else begin
            mem_req_o <= 1'b0;
            rsp_vld   <= mem_req_o & ~desel;
            rsp_tx    <= req_tx;

            // Read data arrives one cycle after the strobe; steer it to
            // the shifter (first fetch) or the holding register (prefetch).
            if (rsp_vld && !desel) begin
                if (rsp_tx) begin
                    tx_sr <= mem_data_i;
                end else begin
                    hold_q <= mem_data_i;
                end
            end

            if (desel) begin
                state     <= ST_IDLE;
                bit_cnt   <= '0;
                pref_pend <= 1'b0;
                miso_o    <= 1'b0;
                miso_oe_o <= 1'b0;
                busy_o    <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        state   <= ST_CMD;
                        bit_cnt <= '0;
                        busy_o  <= 1'b1;
                    end

                    ST_CMD: begin
                        if (rise) begin
                            cmd_sr <= cmd_nxt[6:0];
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= '0;
                                unique case (1'b1)
                                    (cmd_nxt == READ_CMD): begin
                                        state <= ST_ADDR;
                                    end
                                    (cmd_nxt == JEDEC_CMD): begin
                                        state     <= ST_ID;
                                        id_sr     <= JEDEC_ID;
                                        miso_oe_o <= 1'b1;
                                    end
                                    default: begin
                                        state <= ST_IGNORE;
                                    end
                                endcase
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end

                    ST_ADDR: begin
                        if (rise) begin
                            addr_sr <= addr_nxt[22:0];
                            if (bit_cnt == 5'd23) begin
                                bit_cnt    <= '0;
                                mem_req_o  <= 1'b1;
                                mem_addr_o <= addr_nxt;
                                req_tx     <= 1'b1;
                                pref_pend  <= 1'b1;
                                miso_oe_o  <= 1'b1;
                                state      <= ST_DATA;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end

                    ST_DATA: begin
                        // Back-to-back strobe right after the first fetch
                        // fills the holding register before the first fall.
                        if (pref_pend) begin
                            pref_pend  <= 1'b0;
                            mem_req_o  <= 1'b1;
                            mem_addr_o <= mem_addr_o + 24'd1;
                            req_tx     <= 1'b0;
                        end
                        if (fall) begin
                            miso_o <= tx_sr[7];
                            if (bit_cnt == 5'd7) begin
                                bit_cnt    <= '0;
                                tx_sr      <= hold_q;
                                mem_req_o  <= 1'b1;
                                mem_addr_o <= mem_addr_o + 24'd1;
                                req_tx     <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                                tx_sr   <= {tx_sr[6:0], 1'b0};
                            end
                        end
                    end

                    ST_ID: begin
                        if (fall) begin
                            miso_o <= id_sr[23];
                            if (bit_cnt == 5'd23) begin
                                bit_cnt <= '0;
                                id_sr   <= JEDEC_ID;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                                id_sr   <= {id_sr[22:0], 1'b0};
                            end
                        end
                    end

                    ST_IGNORE: begin
                        miso_oe_o <= 1'b0;
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
